// File: rtl/am_pkg.sv
// Shared types, constants and carrier-table builder for the quadrature AM chain.
// Used by am_modulator (optionally built with AM_LC_EN) and the receiver oscillator.
package am_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int LC_OFFSET  = 2 ** (DW_DEFAULT - 2);

    typedef logic signed [DW_DEFAULT-1:0]   sample_t;
    typedef logic signed [2*DW_DEFAULT:0]   prod_t;
    typedef logic signed [2*DW_DEFAULT-1:0] y_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int     FRAC  = 28;
    localparam longint PI_FX = 64'sd843314857;  // pi * 2^FRAC

    // round(amp * cos(2*pi*k / 2^pw)) for the first quadrant, via a fixed-point Taylor series
    function automatic int quarter_cos(input int k, input int pw, input int amp);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (64'sd2 * PI_FX * longint'(k)) >>> pw;
        x2   = (x * x) >>> FRAC;
        term = 64'sd1 <<< FRAC;
        acc  = term;
        for (int n = 1; n <= 9; n++) begin
            term = -((term * x2) >>> FRAC) / longint'((2 * n - 1) * (2 * n));
            acc  = acc + term;
        end
        return int'((longint'(amp) * acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

endpackage

// File: rtl/am_carrier_rom.sv
// Combinational cos/sin carrier lookup built from a quarter-wave table plus symmetry.
module am_carrier_rom
    import am_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int PHASE_W = 10
) (
    input  logic [PHASE_W-1:0]   phase,
    output logic signed [DW-1:0] cos_val,
    output logic signed [DW-1:0] sin_val
);

    localparam int Q   = 2 ** (PHASE_W - 2);
    localparam int AMP = 2 ** (DW - 1) - 1;

    logic signed [DW-1:0] qtab_s [Q+1];

    for (genvar i = 0; i <= Q; i++) begin : g_qtab
        localparam int QV = quarter_cos(i, PHASE_W, AMP);
        assign qtab_s[i] = DW'(QV);
    end

    // Maps a phase to {negate, quarter-table index}
    function automatic logic [PHASE_W-1:0] fold(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-2:0] r;
        logic [PHASE_W-2:0] m;
        r = {1'b0, p[PHASE_W-3:0]};
        m = (PHASE_W-1)'(Q) - r;
        case (p[PHASE_W-1:PHASE_W-2])
            2'd0:    fold = {1'b0, r};
            2'd1:    fold = {1'b1, m};
            2'd2:    fold = {1'b1, r};
            2'd3:    fold = {1'b0, m};
            default: fold = {1'b0, r};
        endcase
    endfunction

    logic [PHASE_W-1:0] sphase_s;
    logic [PHASE_W-1:0] cfold_s;
    logic [PHASE_W-1:0] sfold_s;

    // sin(p) is cos(p - quarter turn)
    always_comb begin
        sphase_s = phase - PHASE_W'(Q);
        cfold_s  = fold(phase);
        sfold_s  = fold(sphase_s);
        if (cfold_s[PHASE_W-1]) begin
            cos_val = -qtab_s[cfold_s[PHASE_W-2:0]];
        end else begin
            cos_val = qtab_s[cfold_s[PHASE_W-2:0]];
        end
        if (sfold_s[PHASE_W-1]) begin
            sin_val = -qtab_s[sfold_s[PHASE_W-2:0]];
        end else begin
            sin_val = qtab_s[sfold_s[PHASE_W-2:0]];
        end
    end

endmodule

// File: rtl/am_modulator.sv
// Quadrature AM transmitter: hold each message pair HOLD clocks, mix with NCO, sum.
// Define AM_LC_EN for large-carrier AM (cosine message offset by LC_OFFSET).
module am_modulator
    import am_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int PHASE_W   = 10,
    parameter int PHASE_INC = 256,
    parameter int HOLD      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   msg1,
    input  logic signed [DW-1:0]   msg2,
    output logic                   out_valid,
    output logic signed [2*DW-1:0] y
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int PW = 2 * DW + 1;
`ifdef AM_LC_EN
    localparam int M1W = DW + 1;
`else
    localparam int M1W = DW;
`endif

    state_t               state_r, state_nxt_s;
    logic [CW-1:0]        cnt_r, cnt_nxt_s;
    logic signed [DW-1:0] h1_r, h2_r, h1_nxt_s, h2_nxt_s;
    logic [PHASE_W-1:0]   phase_r;
    logic                 accept_s;
    logic signed [DW-1:0] rom_cos_s, rom_sin_s;

    logic signed [M1W-1:0] a_m1_nxt_s, a_m1_r;
    logic signed [DW-1:0]  a_m2_r, a_cos_r, a_sin_r;
    logic                  a_v_r;
    logic signed [PW-1:0]  p1_nxt_s, p2_nxt_s, p1_r, p2_r;
    logic                  b_v_r;
    logic signed [PW:0]    sum_s;

    am_carrier_rom #(.DW(DW), .PHASE_W(PHASE_W)) u_rom (
        .phase   (phase_r),
        .cos_val (rom_cos_s),
        .sin_val (rom_sin_s)
    );

    assign in_ready = (state_r == IDLE) || ((state_r == RUN) && (cnt_r == '0));
    assign accept_s = in_valid && in_ready;

    // Hold FSM: a new pair can land on the last hold clock, so streams have no bubble
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        h1_nxt_s    = h1_r;
        h2_nxt_s    = h2_r;
        if (accept_s) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = CW'(HOLD - 1);
            h1_nxt_s    = msg1;
            h2_nxt_s    = msg2;
        end else begin
            case (state_r)
                RUN: begin
                    if (cnt_r != '0) begin
                        cnt_nxt_s = cnt_r - CW'(1);
                    end else begin
                        state_nxt_s = IDLE;
                        h1_nxt_s    = '0;
                        h2_nxt_s    = '0;
                    end
                end
                IDLE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Control registers and free-running NCO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            h1_r    <= '0;
            h2_r    <= '0;
            phase_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            h1_r    <= h1_nxt_s;
            h2_r    <= h2_nxt_s;
            phase_r <= phase_r + PHASE_W'(PHASE_INC);
        end
    end

`ifdef AM_LC_EN
    assign a_m1_nxt_s = {h1_r[DW-1], h1_r} + M1W'(LC_OFFSET);
`else
    assign a_m1_nxt_s = h1_r;
`endif

    assign p1_nxt_s = PW'(a_m1_r) * PW'(a_cos_r);
    assign p2_nxt_s = PW'(a_m2_r) * PW'(a_sin_r);
    assign sum_s    = (PW + 1)'(p1_r) + (PW + 1)'(p2_r);

    // Three-stage mixer pipeline: operands, products, sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_m1_r    <= '0;
            a_m2_r    <= '0;
            a_cos_r   <= '0;
            a_sin_r   <= '0;
            a_v_r     <= 1'b0;
            p1_r      <= '0;
            p2_r      <= '0;
            b_v_r     <= 1'b0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            a_m1_r    <= a_m1_nxt_s;
            a_m2_r    <= h2_r;
            a_cos_r   <= rom_cos_s;
            a_sin_r   <= rom_sin_s;
            a_v_r     <= (state_r == RUN);
            p1_r      <= p1_nxt_s;
            p2_r      <= p2_nxt_s;
            b_v_r     <= a_v_r;
            y         <= sum_s[2*DW-1:0];
            out_valid <= b_v_r;
        end
    end

endmodule

// File: doc/am_modulator.md
Name: am_modulator

Overview:
- Quadrature AM transmitter; the source end of the two-channel AM receive chain.
- Accepts paired message samples (msg1 for the cosine channel, msg2 for the sine channel) through a valid/ready handshake.
- Holds each pair for HOLD clocks (upsampling), multiplies by an on-chip NCO carrier, and sums the two products into one modulated sample stream `y`.
- `y` feeds the receiver top in system-level loopback benches.

Parameters:
- DW, 16, message and carrier sample width in bits (signed).
- PHASE_W, 10, NCO phase accumulator width; the LUT has 2^PHASE_W entries.
- PHASE_INC, 256, phase increment per clock; carrier frequency = fclk*PHASE_INC/2^PHASE_W.
- HOLD, 8, clocks each accepted message pair is held; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  msg1/msg2 carry a valid pair.
- in_ready  out  1  block can accept a pair this cycle.
- msg1  in  DW  signed message for the cosine channel.
- msg2  in  DW  signed message for the sine channel.
- out_valid  out  1  `y` is valid this cycle.
- y  out  2*DW  signed modulated sample.

Behaviour:
Reset:
- Async, active-high.
- phase=0, hold regs h1=h2=0, cnt=0, state=IDLE.
- All pipeline data and valid bits are 0, so y=0 and out_valid=0.
- in_ready=1 while rst is low and state=IDLE.
- Asserting rst mid-operation discards the held pair and all in-flight samples.

NCO:
- phase <= phase + PHASE_INC every clock, mod 2^PHASE_W; it runs freely in all states, including IDLE.
- cos_lut[p] = round(32767*cos(2*pi*p/2^PHASE_W)); sin_lut[p] is the same with sin.
- The LUT is read combinationally from the current phase.

State machine (IDLE, RUN):
- in_ready = (state==IDLE) || (state==RUN && cnt==0). It is combinational from state and cnt, never from in_valid.
- Accept = in_valid && in_ready. On accept: h1<=msg1, h2<=msg2, cnt<=HOLD-1, state<=RUN.
- RUN with cnt>0: cnt decrements.
- RUN with cnt==0 and no accept: state<=IDLE, h1=h2=0.
- RUN with cnt==0 and accept: the new pair loads with no bubble, so continuous valid gives exactly HOLD clocks per pair.
- HOLD=1: in_ready stays high throughout RUN.

Datapath, 3 registered stages:
- A: registers a_m1=h1, a_m2=h2, a_cos=cos_lut[phase], a_sin=sin_lut[phase], a_v=(state==RUN).
- B: registers p1=a_m1*a_cos and p2=a_m2*a_sin as signed, full precision, plus b_v=a_v.
- C: registers y=p1+p2 (computed 2*DW+2 wide, truncated to 2*DW) and out_valid=b_v.
- Truncation is lossless: |y| <= sqrt(2)*32768*32767 < 2^31.
- A pair loaded at edge t first appears on y after edge t+3 and occupies exactly HOLD consecutive out_valid cycles.
- In IDLE the pipeline drains: valid bits go to 0 and y becomes 0 after 3 clocks.

Optional Feature:
- Macro: AM_LC_EN (large-carrier AM).
- Defined: stage A computes a_m1 = h1 + LC_OFFSET (LC_OFFSET = 2^(DW-2) = 8192), sign-extended to DW+1 bits. a_m2 is unchanged.
  - The carrier is therefore present even for zero message and in IDLE: a_m1=8192 while h1=0.
  - out_valid still follows state.
  - Worst case |y| ~ 1.72e9 fits in 2*DW bits; truncation remains lossless.
- Undefined: suppressed-carrier behaviour as above; a_m1 is DW bits.

Decomposition:
- Package am_pkg:
  - DW default constant and LC_OFFSET.
  - Typedefs: sample_t (signed DW), prod_t (signed 2*DW+1), y_t (signed 2*DW).
  - State enum {IDLE, RUN}.
  - Function building the cos/sin LUT entries.
- Sub-module am_carrier_rom: phase in; cos and sin out, combinational. Shared with the receiver's local oscillator.

Test Plan:
- Assert rst for 3 clocks mid-stream -> same cycle: y=0, out_valid=0, in_ready=1. After release, first out_valid no earlier than 3 clocks after the first accept.
- PHASE_INC=256, msg1=1000, msg2=0, continuous valid -> y repeats period 4 over {32767000, 0, -32767000, 0}. out_valid continuous once filled.
- PHASE_INC=256, msg1=0, msg2=1000 -> same magnitude set, shifted by one clock relative to the previous scenario (quadrature).
- HOLD=8, pairs A then B with in_valid constant high -> in_ready high 1 of every 8 clocks; y uses A for exactly 8 valid cycles, then B for 8.
- Drop in_valid after B -> state IDLE after B's 8 clocks; out_valid falls 3 clocks later; y=0.
- AM_LC_EN defined, msg1=msg2=0, PHASE_INC=256 -> y over {268427264, 0, -268427264, 0}. With AM_LC_EN undefined, y=0.
